// File: rtl/vga_sync.sv
// VGA raster timing generator: divides clock_50 by two into a pixel enable and
// walks the (pixel_x, pixel_y) raster, decoding sync/blanking from next-state counters.
module vga_sync #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clock_50,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic       tick_q, tick_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       disp_q, disp_d;
    logic       fstart_q, fstart_d;

    logic       h_wrap;
    logic       v_wrap;

    always_comb begin
        tick_d   = ~tick_q;
        x_d      = x_q;
        y_d      = y_q;
        h_wrap   = (x_q == H_LAST);
        v_wrap   = (y_q == V_LAST);
        fstart_d = 1'b0;

        if (tick_q) begin
            if (h_wrap) begin
                x_d = '0;
                if (v_wrap) begin
                    y_d      = '0;
                    fstart_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // Decode from the next-state counters so flags line up with pixel_x/pixel_y.
        disp_d  = (x_d < H_VIS) && (y_d < V_VIS);
        hsync_d = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Reset parks the raster on its last position so the first advance lands on (0,0).
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            tick_q   <= 1'b0;
            x_q      <= H_LAST;
            y_q      <= V_LAST;
            hsync_q  <= ~SYNC_ACTIVE;
            vsync_q  <= ~SYNC_ACTIVE;
            disp_q   <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            disp_q   <= disp_d;
            fstart_q <= fstart_d;
        end
    end

    assign pixel_tick  = tick_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = disp_q;
    assign frame_start = fstart_q;

endmodule
